// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone single-transfer master: default bus widths,
// controller state encoding and response status codes.
package wb_pkg;

  localparam int DEF_DWIDTH = 8;
  localparam int DEF_AWIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUS  = 2'd1;
  localparam state_t ST_GAP  = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    RSP_OK  = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2,
    RSP_TMO = 2'd3
  } rsp_status_e;

endpackage

// File: rtl/wb_master_if.sv
// Command, response and Wishbone initiator signals of wb_master; the master
// modport is the controller's view, the slave modport the environment's view.
interface wb_master_if #(
  parameter int DWIDTH = wb_pkg::DEF_DWIDTH,
  parameter int AWIDTH = wb_pkg::DEF_AWIDTH
) ();

  localparam int SW = DWIDTH / 8;

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic [AWIDTH-1:0] cmd_adr_i;
  logic [DWIDTH-1:0] cmd_dat_i;
  logic [SW-1:0]     cmd_sel_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DWIDTH-1:0] rsp_dat_o;
  logic [1:0]        rsp_status_o;

  logic [AWIDTH-1:0] adr_o;
  logic [DWIDTH-1:0] dat_o;
  logic              we_o;
  logic [SW-1:0]     sel_o;
  logic              stb_o;
  logic              cyc_o;
  logic [DWIDTH-1:0] dat_i;
  logic              ack_i;
  logic              err_i;
  logic              rty_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  rsp_ready_i,
    output adr_o, dat_o, we_o, sel_o, stb_o, cyc_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    output rsp_ready_i,
    input  adr_o, dat_o, we_o, sel_o, stb_o, cyc_o,
    output dat_i, ack_i, err_i, rty_i
  );

endinterface

// File: rtl/wb_mst_timer.sv
// Bus-cycle watchdog: counts enabled cycles and flags the cycle in which the
// TIMEOUT-th consecutive unterminated cycle is reached. Saturates, never wraps.
module wb_mst_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (int'(cnt) < TIMEOUT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Current cycle counts too, so the abort lands right after cycle TIMEOUT.
  assign expired = enable && ((int'(cnt) + 1) >= TIMEOUT);

endmodule

// File: rtl/wb_master.sv
// Single-transfer Wishbone initiator: takes one command, runs the bus cycle with
// retry and timeout handling, and returns read data plus a status code.
module wb_master import wb_pkg::*; #(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_master_if.master bus
);

  localparam int SW = DWIDTH / 8;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t            state;
  logic              alive;
  logic [RW-1:0]     rty_cnt;
  logic              we;
  logic [AWIDTH-1:0] adr;
  logic [DWIDTH-1:0] dat;
  logic [SW-1:0]     sel;
  logic [DWIDTH-1:0] rsp_dat;
  rsp_status_e       status;

  logic in_bus;
  logic ready;
  logic take;
  logic t_err;
  logic t_rty;
  logic t_ack;
  logic term;
  logic retry_ok;
  logic expired;

  // alive keeps cmd_ready low during reset and raises it on the first edge after.
  assign in_bus   = (state == ST_BUS);
  assign ready    = alive && (state == ST_IDLE);
  assign take     = ready && bus.cmd_valid_i;
  assign t_err    = in_bus && bus.err_i;
  assign t_rty    = in_bus && bus.rty_i && !bus.err_i;
  assign t_ack    = in_bus && bus.ack_i && !bus.err_i && !bus.rty_i;
  assign term     = t_err || t_rty || t_ack;
  assign retry_ok = (int'(rty_cnt) < MAX_RETRY);

  wb_mst_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (!in_bus),
    .enable  (in_bus && !term),
    .expired (expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      alive   <= 1'b0;
      rty_cnt <= '0;
      we      <= 1'b0;
      adr     <= '0;
      dat     <= '0;
      sel     <= '0;
      rsp_dat <= '0;
      status  <= RSP_OK;
    end else begin
      alive <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (take) begin
            we      <= bus.cmd_we_i;
            adr     <= bus.cmd_adr_i;
            dat     <= bus.cmd_dat_i;
            sel     <= bus.cmd_sel_i;
            rty_cnt <= '0;
            state   <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (t_err) begin
            status <= RSP_ERR;
            state  <= ST_RESP;
          end else if (t_rty) begin
            if (retry_ok) begin
              rty_cnt <= rty_cnt + 1'b1;
              state   <= ST_GAP;
            end else begin
              status <= RSP_RTY;
              state  <= ST_RESP;
            end
          end else if (t_ack) begin
            if (!we) rsp_dat <= bus.dat_i;
            status <= RSP_OK;
            state  <= ST_RESP;
          end else if (expired) begin
            status <= RSP_TMO;
            state  <= ST_RESP;
          end
        end
        ST_GAP:  state <= ST_BUS;
        ST_RESP: if (bus.rsp_ready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o  = ready;
  assign bus.cyc_o        = in_bus;
  assign bus.stb_o        = in_bus;
  assign bus.we_o         = we;
  assign bus.adr_o        = adr;
  assign bus.dat_o        = dat;
  assign bus.sel_o        = sel;
  assign bus.rsp_valid_o  = (state == ST_RESP);
  assign bus.rsp_dat_o    = rsp_dat;
  assign bus.rsp_status_o = status;

endmodule

// File: tb/tb_wb_master.sv
// Self-checking bench for wb_master: scripted Wishbone responder plus a response
// scoreboard fed when each command is issued.
module tb_wb_master;
  import wb_pkg::*;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk = ~clk;

  wb_master_if #(.DWIDTH(8), .AWIDTH(16)) bus ();

  wb_master #(
    .DWIDTH    (8),
    .AWIDTH    (16),
    .MAX_RETRY (3),
    .TIMEOUT   (255)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] dat;
    logic [1:0] st;
    bit         chk_dat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Responder / monitor state
  int         wait_cyc   = 0;
  int         rty_left   = 0;
  bit         both_mode  = 0;
  bit         err_mode   = 0;
  bit         no_term    = 0;
  bit         force_term = 0;
  logic [7:0] rd_dat     = 8'h00;
  logic       exp_we     = 1'b0;
  logic [15:0] exp_adr   = 16'h0;
  logic [7:0] exp_dat    = 8'h0;
  logic [0:0] exp_sel    = 1'b0;

  bit         in_stb     = 0;
  int         n_in       = 0;
  int         stb_count  = 0;
  int         cyc_cycles = 0;
  int         rv_cycles  = 0;
  int         gap_run    = -1;
  int         gap_min    = 1000;
  int         gap_max    = 0;
  int         bus_bad    = 0;
  int         rsp_bad    = 0;
  int         hold_cfg   = 0;
  int         hold       = 0;
  int         rsp_done   = 0;
  bit         seen       = 0;
  logic [7:0] snap_dat;
  logic [1:0] snap_st;

  always @(negedge clk) begin
    if (bus.cyc_o) cyc_cycles++;
    if (bus.rsp_valid_o) rv_cycles++;
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    bus.rty_i = 1'b0;
    bus.dat_i = rd_dat;
    if (bus.stb_o) begin
      if (!in_stb) begin
        in_stb = 1;
        n_in   = 0;
        stb_count++;
        if (gap_run > 0) begin
          if (gap_run < gap_min) gap_min = gap_run;
          if (gap_run > gap_max) gap_max = gap_run;
        end
        gap_run = -1;
      end else begin
        n_in++;
      end
      if (bus.adr_o !== exp_adr || bus.we_o !== exp_we || bus.sel_o !== exp_sel ||
          (exp_we && bus.dat_o !== exp_dat))
        bus_bad++;
      if (!no_term && n_in == wait_cyc) begin
        if (err_mode) begin
          bus.err_i = 1'b1;
          bus.ack_i = 1'b1;
          bus.rty_i = 1'b1;
        end else if (rty_left > 0) begin
          bus.rty_i = 1'b1;
          bus.ack_i = both_mode;
          rty_left--;
        end else begin
          bus.ack_i = 1'b1;
        end
      end
    end else begin
      if (in_stb) begin
        in_stb  = 0;
        gap_run = 1;
      end else if (gap_run > 0) begin
        gap_run++;
      end
    end
    if (force_term) begin
      bus.ack_i = 1'b1;
      bus.err_i = 1'b1;
      bus.rty_i = 1'b1;
    end

    if (bus.rsp_valid_o) begin
      if (!seen) begin
        seen     = 1;
        snap_dat = bus.rsp_dat_o;
        snap_st  = bus.rsp_status_o;
        hold     = hold_cfg;
      end else if (bus.rsp_dat_o !== snap_dat || bus.rsp_status_o !== snap_st) begin
        rsp_bad++;
      end
      if (bus.cmd_ready_o) rsp_bad++;
      if (hold == 0) begin
        bus.rsp_ready_i = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(bus.rsp_status_o), 32'hFF);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_status", 32'(bus.rsp_status_o), 32'(mon_e.st));
          if (mon_e.chk_dat) check("rsp_dat", 32'(bus.rsp_dat_o), 32'(mon_e.dat));
        end
        rsp_done++;
      end else begin
        hold--;
        bus.rsp_ready_i = 1'b0;
      end
    end else begin
      seen            = 0;
      bus.rsp_ready_i = 1'b0;
    end
  end

  task automatic issue(input bit we, input logic [15:0] adr, input logic [7:0] wdat,
                       input logic [0:0] sel);
    int k;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = wdat;
    bus.cmd_sel_i   = sel;
    bus.cmd_valid_i = 1'b1;
    k = 0;
    while (!bus.cmd_ready_o && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (!bus.cmd_ready_o) begin
      check("cmd_handshake_timeout", 32'(bus.cmd_ready_o), 32'd1);
      bus.cmd_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.cmd_valid_i = 1'b0;
      check("cyc_1cycle_latency", 32'(bus.cyc_o), 32'd1);
      #1;
    end
  endtask

  task automatic clear_stats();
    stb_count  = 0;
    cyc_cycles = 0;
    rv_cycles  = 0;
    gap_run    = -1;
    gap_min    = 1000;
    gap_max    = 0;
    bus_bad    = 0;
    rsp_bad    = 0;
  endtask

  task automatic run_cmd(input string name, input bit we, input logic [15:0] adr,
                         input logic [7:0] wdat, input logic [0:0] sel, input logic [7:0] rdat,
                         input int wt, input int rty_n, input bit both, input bit errm,
                         input bit noterm, input int hld, input logic [1:0] st,
                         input int n_stb, input int n_cyc);
    exp_t e;
    int   d0;
    int   k;
    clear_stats();
    wait_cyc  = wt;
    rty_left  = rty_n;
    both_mode = both;
    err_mode  = errm;
    no_term   = noterm;
    hold_cfg  = hld;
    rd_dat    = rdat;
    exp_we    = we;
    exp_adr   = adr;
    exp_dat   = wdat;
    exp_sel   = sel;
    e.dat     = rdat;
    e.st      = st;
    e.chk_dat = !we && (st == RSP_OK);
    sb.push_back(e);
    d0 = rsp_done;
    issue(we, adr, wdat, sel);
    k = 0;
    while (rsp_done == d0 && k < 400) begin
      @(posedge clk);
      #2;
      k++;
    end
    check({name, ".rsp_seen"}, 32'(rsp_done - d0), 32'd1);
    check({name, ".ready_after_rsp"}, 32'(bus.cmd_ready_o), 32'd1);
    check({name, ".stb_count"}, 32'(stb_count), 32'(n_stb));
    check({name, ".cyc_cycles"}, 32'(cyc_cycles), 32'(n_cyc));
    check({name, ".bus_fields_bad"}, 32'(bus_bad), 32'd0);
    check({name, ".rsp_unstable"}, 32'(rsp_bad), 32'd0);
    check({name, ".rsp_valid_cycles"}, 32'(rv_cycles), 32'(hld + 1));
    if (n_stb > 1) begin
      check({name, ".gap_min"}, 32'(gap_min), 32'd1);
      check({name, ".gap_max"}, 32'(gap_max), 32'd1);
    end
    no_term = 0;
    err_mode = 0;
    both_mode = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, 0 vs bounded run");
    $fatal(1);
  end

  initial begin
    int rv0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 16'h0;
    bus.cmd_dat_i   = 8'h0;
    bus.cmd_sel_i   = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    check("rst.cyc_o", 32'(bus.cyc_o), 32'd0);
    check("rst.stb_o", 32'(bus.stb_o), 32'd0);
    check("rst.we_o", 32'(bus.we_o), 32'd0);
    check("rst.adr_o", 32'(bus.adr_o), 32'd0);
    check("rst.dat_o", 32'(bus.dat_o), 32'd0);
    check("rst.sel_o", 32'(bus.sel_o), 32'd0);
    check("rst.rsp_valid_o", 32'(bus.rsp_valid_o), 32'd0);
    check("rst.rsp_dat_o", 32'(bus.rsp_dat_o), 32'd0);
    check("rst.rsp_status_o", 32'(bus.rsp_status_o), 32'(RSP_OK));
    check("rst.cmd_ready_o", 32'(bus.cmd_ready_o), 32'd0);
    rst_i = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(bus.cmd_ready_o), 32'd0);
    @(posedge clk);
    #1;
    check("ready_at_first_edge", 32'(bus.cmd_ready_o), 32'd1);
    #1;

    //         name       we  adr      wdat   sel   rdat  wt rty both err noterm hold status   stb cyc
    run_cmd("read_ok",    0, 16'h0010, 8'h00, 1'b1, 8'hA5, 2, 0, 0, 0, 0, 0, RSP_OK,  1, 3);
    run_cmd("write_ok",   1, 16'h1234, 8'h5A, 1'b1, 8'h00, 0, 0, 0, 0, 0, 0, RSP_OK,  1, 1);
    run_cmd("retry2_ok",  0, 16'h0F0F, 8'h00, 1'b1, 8'h3C, 0, 2, 0, 0, 0, 0, RSP_OK,  3, 3);
    run_cmd("retry4_rty", 1, 16'h2222, 8'h11, 1'b1, 8'h00, 0, 4, 0, 0, 0, 0, RSP_RTY, 4, 4);
    run_cmd("rty_ack",    0, 16'h0404, 8'h00, 1'b1, 8'hC3, 0, 1, 1, 0, 0, 0, RSP_OK,  2, 2);
    run_cmd("err_ack",    0, 16'h0BAD, 8'h00, 1'b1, 8'h99, 1, 0, 0, 1, 0, 0, RSP_ERR, 1, 2);
    run_cmd("timeout",    0, 16'h7777, 8'h00, 1'b1, 8'h00, 0, 0, 0, 0, 1, 0, RSP_TMO, 1, 255);
    run_cmd("backpress",  0, 16'h0042, 8'h00, 1'b1, 8'h77, 1, 0, 0, 0, 0, 5, RSP_OK,  1, 2);

    // Reset in the middle of a bus cycle: no response may follow.
    clear_stats();
    no_term = 1;
    exp_we  = 1'b0;
    exp_adr = 16'h0ABC;
    exp_sel = 1'b1;
    issue(1'b0, 16'h0ABC, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst.cyc_o", 32'(bus.cyc_o), 32'd0);
    check("midrst.stb_o", 32'(bus.stb_o), 32'd0);
    check("midrst.cmd_ready_o", 32'(bus.cmd_ready_o), 32'd0);
    rv0 = rv_cycles;
    repeat (3) @(posedge clk);
    #2;
    rst_i   = 1'b1;
    no_term = 0;
    @(posedge clk);
    #2;
    check("midrst.ready_after", 32'(bus.cmd_ready_o), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    check("midrst.no_rsp", 32'(rv_cycles - rv0), 32'd0);

    // Terminations while idle are ignored.
    clear_stats();
    force_term = 1;
    repeat (3) @(posedge clk);
    #2;
    force_term = 0;
    @(posedge clk);
    #2;
    check("idle_term.rsp_valid", 32'(rv_cycles), 32'd0);
    check("idle_term.cyc", 32'(cyc_cycles), 32'd0);
    check("idle_term.ready", 32'(bus.cmd_ready_o), 32'd1);

    run_cmd("read_after", 0, 16'h00FE, 8'h00, 1'b1, 8'h5C, 1, 0, 0, 0, 0, 0, RSP_OK, 1, 2);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
